// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: op encodings, FSM state type
// and the default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/alu_latency_counter.sv
// Down-counter that times the ALU issue window: load, decrement, zero flag.
module alu_latency_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/alu_cmd_driver.sv
// Valid/ready front end for the registered add/sub ALU; one command in flight.
// Optional self-check against an internal model: define ALU_CMD_DRIVER_CHECK_EN.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_CMD_DRIVER_CHECK_EN
    output logic             chk_err,
`endif
    output logic [1:0]       dbg_state,
    output logic             busy
);

    // Handshakes: a transfer happens on any rising edge where valid and ready
    // are both high; valid must then hold with stable payload until that edge.

    localparam int         CNT_W  = 4;
    localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_alu_x;
    logic [WIDTH-1:0] r_alu_y;
    logic [1:0]       r_alu_ctrl;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_cmd_ready;
    logic             r_busy;

    logic w_accept;
    logic w_cnt_dec;
    logic w_cnt_zero;

    assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
    assign w_cnt_dec = (r_state == ST_ISSUE) && !w_cnt_zero;

    alu_latency_counter #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (LAT_M1),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_alu_x     <= '0;
            r_alu_y     <= '0;
            r_alu_ctrl  <= OP_HOLD;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_alu_ctrl <= OP_HOLD;
                    if (cmd_valid) begin
                        r_alu_x     <= cmd_x;
                        r_alu_y     <= cmd_y;
                        r_alu_ctrl  <= cmd_op;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Drop back to hold so the ALU keeps the result we are about to read.
                    if (w_cnt_zero) begin
                        r_alu_ctrl <= OP_HOLD;
                        r_state    <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_rsp_data  <= alu_result;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_alu_ctrl  <= OP_HOLD;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_CMD_DRIVER_CHECK_EN
    logic [WIDTH-1:0] r_exp;
    logic             r_chk_err;

    // Hold is predicted from the last returned response, which is what the ALU still holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp     <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_accept) begin
                case (cmd_op)
                    OP_CLEAR: r_exp <= '0;
                    OP_ADD:   r_exp <= cmd_x + cmd_y;
                    OP_SUB:   r_exp <= cmd_x - cmd_y;
                    default:  r_exp <= r_rsp_data;
                endcase
            end
            if ((r_state == ST_CAPTURE) && (alu_result != r_exp)) begin
                r_chk_err <= 1'b1;
            end
        end
    end

    assign chk_err = r_chk_err;
`endif

    assign alu_x     = r_alu_x;
    assign alu_y     = r_alu_y;
    assign alu_ctrl  = r_alu_ctrl;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule
